// File: rtl/id_ex_stage_pkg.sv
// Shared types for the decode->execute boundary: ALU op encoding, forward-select
// codes and the held instruction record.
package id_ex_stage_pkg;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_AND   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_XOR   = 5'd4,
      ALU_SLL   = 5'd5,
      ALU_SRL   = 5'd6,
      ALU_SRA   = 5'd7,
      ALU_SLT   = 5'd8,
      ALU_SLTU  = 5'd9,
      ALU_PASSB = 5'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      alu_op_e          op;
      logic [RW-1:0]    rs1;
      logic [RW-1:0]    rs2;
      logic [DW-1:0]    rs1_data;
      logic [DW-1:0]    rs2_data;
      logic [DW-1:0]    imm;
      logic [DW-1:0]    pc;
      logic [RW-1:0]    rd;
      logic             reg_write;
      logic             use_imm;
      logic             use_pc;
   } id_ex_t;

   // x0 is hardwired, so a write to it is never a forwarding source.
   function automatic logic fwd_hit(input logic we, input logic [RW-1:0] src_rd,
                                    input logic [RW-1:0] rs);
      return we && (src_rd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Combinational forwarding mux for one source operand: EX/MEM beats MEM/WB beats
// the held register-file value; x0 always reads as zero.
module id_ex_stage_operand_fwd
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DW,
   parameter int unsigned REG_ADDR_W = RW
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [DATA_WIDTH-1:0] rs_data_i,
   input  logic [REG_ADDR_W-1:0] exm_rd_i,
   input  logic                  exm_we_i,
   input  logic [DATA_WIDTH-1:0] exm_result_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_we_i,
   input  logic [DATA_WIDTH-1:0] wb_result_i,
   output fwd_sel_e              sel_o,
   output logic [DATA_WIDTH-1:0] val_o
);

   always_comb begin
      sel_o = FWD_RF;
      val_o = rs_data_i;
      if (fwd_hit(exm_we_i, exm_rd_i, rs_i)) begin
         sel_o = FWD_EXM;
         val_o = exm_result_i;
      end else if (fwd_hit(wb_we_i, wb_rd_i, rs_i)) begin
         sel_o = FWD_WB;
         val_o = wb_result_i;
      end else if (rs_i == '0) begin
         val_o = '0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with valid/ready handshake, flush, operand
// forwarding and imm/PC selection feeding a combinational ALU.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DW,
   parameter int unsigned REG_ADDR_W = RW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            in_alu_op,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   input  logic [DATA_WIDTH-1:0] in_rs1_data,
   input  logic [DATA_WIDTH-1:0] in_rs2_data,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic                  in_use_imm,
   input  logic                  in_use_pc,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] exm_rd,
   input  logic                  exm_we,
   input  logic [DATA_WIDTH-1:0] exm_result,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_we,
   input  logic [DATA_WIDTH-1:0] wb_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_reg_write,
   output logic [DATA_WIDTH-1:0] out_pc
);

   id_ex_t                held_q, held_d;
   logic                  valid_q, valid_d;
   logic                  accept, consume, stall;
   fwd_sel_e              sel_a, sel_b;
   logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
   logic                  unused_sel;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign consume  = valid_q && out_ready;
   assign stall    = valid_q && !out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         held_q  <= held_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      held_d  = held_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d          = 1'b0;
         held_d.reg_write = 1'b0;
      end else if (accept) begin
         valid_d          = 1'b1;
         held_d.op        = alu_op_e'(in_alu_op);
         held_d.rs1       = in_rs1;
         held_d.rs2       = in_rs2;
         // Regfile is written and read in the same cycle; take the value being written.
         held_d.rs1_data  = fwd_hit(wb_we, wb_rd, in_rs1) ? wb_result : in_rs1_data;
         held_d.rs2_data  = fwd_hit(wb_we, wb_rd, in_rs2) ? wb_result : in_rs2_data;
         held_d.imm       = in_imm;
         held_d.pc        = in_pc;
         held_d.rd        = in_rd;
         held_d.reg_write = in_reg_write;
         held_d.use_imm   = in_use_imm;
         held_d.use_pc    = in_use_pc;
      end else begin
         if (consume) valid_d = 1'b0;
         // A WB retiring during a stall would otherwise vanish before we consume.
         if (stall) begin
            if (fwd_hit(wb_we, wb_rd, held_q.rs1)) held_d.rs1_data = wb_result;
            if (fwd_hit(wb_we, wb_rd, held_q.rs2)) held_d.rs2_data = wb_result;
         end
      end
   end

   id_ex_stage_operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs_i         (held_q.rs1),
      .rs_data_i    (held_q.rs1_data),
      .exm_rd_i     (exm_rd),
      .exm_we_i     (exm_we),
      .exm_result_i (exm_result),
      .wb_rd_i      (wb_rd),
      .wb_we_i      (wb_we),
      .wb_result_i  (wb_result),
      .sel_o        (sel_a),
      .val_o        (fwd_a)
   );

   id_ex_stage_operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs_i         (held_q.rs2),
      .rs_data_i    (held_q.rs2_data),
      .exm_rd_i     (exm_rd),
      .exm_we_i     (exm_we),
      .exm_result_i (exm_result),
      .wb_rd_i      (wb_rd),
      .wb_we_i      (wb_we),
      .wb_result_i  (wb_result),
      .sel_o        (sel_b),
      .val_o        (fwd_b)
   );

   assign unused_sel = ^{sel_a, sel_b};

   assign out_valid     = valid_q;
   assign alu_op        = held_q.op;
   assign alu_a         = held_q.use_pc  ? held_q.pc  : fwd_a;
   assign alu_b         = held_q.use_imm ? held_q.imm : fwd_b;
   assign out_rd        = held_q.rd;
   assign out_reg_write = held_q.reg_write;
   assign out_pc        = held_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected slot contents are queued at issue and
// compared by a monitor whenever the DUT hands the slot downstream.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [4:0]  in_alu_op, in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic        in_use_imm, in_use_pc, in_reg_write;
   logic [4:0]  exm_rd, wb_rd;
   logic        exm_we, wb_we;
   logic [31:0] exm_result, wb_result;
   logic        out_valid, out_ready;
   logic [4:0]  alu_op, out_rd;
   logic [31:0] alu_a, alu_b, out_pc;
   logic        out_reg_write;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
      .in_pc(in_pc), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_pc(out_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic exp_t ex(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic we, input logic [31:0] pc);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.pc = pc;
      return e;
   endfunction

   // Scoreboard monitor: one pop per consumed slot.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL mon_unexpected: consumed op %h a %h b %h with nothing expected",
                     alu_op, alu_a, alu_b);
         end else begin
            mon_e = sb.pop_front();
            chk("mon_op", {27'd0, alu_op}, {27'd0, mon_e.op});
            chk("mon_a", alu_a, mon_e.a);
            chk("mon_b", alu_b, mon_e.b);
            chk("mon_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
            chk("mon_we", {31'd0, out_reg_write}, {31'd0, mon_e.we});
            chk("mon_pc", out_pc, mon_e.pc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] op, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic ui, input logic up, input logic [31:0] pc,
                         input logic [4:0] rd, input logic we);
      in_alu_op = op; in_rs1 = r1; in_rs1_data = d1; in_rs2 = r2; in_rs2_data = d2;
      in_imm = imm; in_use_imm = ui; in_use_pc = up; in_pc = pc; in_rd = rd; in_reg_write = we;
   endtask

   // Present the already-set inputs until accepted (bounded), then drop in_valid.
   task automatic issue();
      int n;
      n = 0;
      in_valid = 1'b1;
      while (!(in_ready && !flush) && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         n_checks++;
         n_err++;
         $display("FAIL issue_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_in(5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
      exm_rd = 5'd0; exm_we = 1'b0; exm_result = 32'd0;
      wb_rd = 5'd0; wb_we = 1'b0; wb_result = 32'd0;

      // Reset
      step(); step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // Plain ADD, no hazards
      sb.push_back(ex(5'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'h10));
      set_in(5'd0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, 32'h10, 5'd3, 1'b1);
      issue();
      chk("add_out_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("add_drained", {31'd0, out_valid}, 32'd0);

      // Forwarding priority on a stalled instruction
      out_ready = 1'b0;
      set_in(5'd1, 5'd3, 32'h11, 5'd5, 32'h22, 32'd0, 1'b0, 1'b0, 32'h20, 5'd6, 1'b1);
      issue();
      exm_rd = 5'd3; exm_we = 1'b1; exm_result = 32'hAA;
      wb_rd  = 5'd3; wb_we  = 1'b1; wb_result  = 32'hBB;
      #1 chk("prio_exm", alu_a, 32'hAA);
      exm_we = 1'b0;
      #1 chk("prio_wb", alu_a, 32'hBB);
      wb_we = 1'b0;
      #1;
      sb.push_back(ex(5'd1, 32'h11, 32'h22, 5'd6, 1'b1, 32'h20));
      out_ready = 1'b1;
      step();

      // x0 never forwards and reads as zero
      sb.push_back(ex(5'd2, 32'd0, 32'h33, 5'd1, 1'b1, 32'h24));
      set_in(5'd2, 5'd0, 32'h55, 5'd7, 32'h33, 32'd0, 1'b0, 1'b0, 32'h24, 5'd1, 1'b1);
      issue();
      exm_rd = 5'd0; exm_we = 1'b1; exm_result = 32'h77;
      step();
      exm_we = 1'b0;

      // Accept-cycle WB bypass
      sb.push_back(ex(5'd4, 32'h5A5A, 32'h2, 5'd2, 1'b1, 32'h28));
      set_in(5'd4, 5'd5, 32'h1, 5'd6, 32'h2, 32'd0, 1'b0, 1'b0, 32'h28, 5'd2, 1'b1);
      wb_rd = 5'd5; wb_we = 1'b1; wb_result = 32'h5A5A;
      issue();
      wb_we = 1'b0;
      step();

      // Stall with WB capture; decode holds a second instruction meanwhile
      out_ready = 1'b0;
      set_in(5'd3, 5'd6, 32'h1, 5'd4, 32'h9, 32'd0, 1'b0, 1'b0, 32'h30, 5'd7, 1'b1);
      issue();
      chk("stall_in_ready_c1", {31'd0, in_ready}, 32'd0);
      set_in(5'd0, 5'd8, 32'h3, 5'd9, 32'h4, 32'd0, 1'b0, 1'b0, 32'h34, 5'd10, 1'b1);
      in_valid = 1'b1;
      step();
      exm_rd = 5'd4; exm_we = 1'b1; exm_result = 32'hDEAD;
      wb_rd  = 5'd4; wb_we  = 1'b1; wb_result  = 32'h1234;
      #1 chk("stall_exm_fwd", alu_b, 32'hDEAD);
      chk("stall_in_ready_c2", {31'd0, in_ready}, 32'd0);
      step();
      exm_we = 1'b0; wb_we = 1'b0;
      #1 chk("stall_capture_b", alu_b, 32'h1234);
      chk("stall_in_ready_c3", {31'd0, in_ready}, 32'd0);
      step();
      chk("stall_capture_hold", alu_b, 32'h1234);
      chk("stall_a_frozen", alu_a, 32'h1);
      chk("stall_op_frozen", {27'd0, alu_op}, 32'd3);
      chk("stall_rd_frozen", {27'd0, out_rd}, 32'd7);
      chk("stall_in_ready_c4", {31'd0, in_ready}, 32'd0);
      sb.push_back(ex(5'd3, 32'h1, 32'h1234, 5'd7, 1'b1, 32'h30));
      sb.push_back(ex(5'd0, 32'h3, 32'h4, 5'd10, 1'b1, 32'h34));
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("replace_out_valid", {31'd0, out_valid}, 32'd1);
      step();

      // Flush while stalled drops held and incoming
      out_ready = 1'b0;
      set_in(5'd4, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 1'b0, 1'b0, 32'h40, 5'd11, 1'b1);
      issue();
      chk("flush_pre_we", {31'd0, out_reg_write}, 32'd1);
      set_in(5'd2, 5'd3, 32'h3, 5'd4, 32'h4, 32'd0, 1'b0, 1'b0, 32'h44, 5'd12, 1'b1);
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_reg_write", {31'd0, out_reg_write}, 32'd0);
      step();
      chk("flush_no_accept", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;

      // Back-to-back stream of 8, no bubbles
      for (int i = 0; i < 8; i++) begin
         sb.push_back(ex(5'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i + 1), 1'b1,
                         32'h1000 + 32'(4 * i)));
         set_in(5'(i), 5'(i + 1), 32'h100 + 32'(i), 5'(i + 10), 32'h200 + 32'(i), 32'd0,
                1'b0, 1'b0, 32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1);
         in_valid = 1'b1;
         if (i > 0) chk("stream_no_bubble", {31'd0, out_valid}, 32'd1);
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("stream_drained", {31'd0, out_valid}, 32'd0);

      // imm / pc selection ignores forwarding
      sb.push_back(ex(5'd0, 32'h100, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h100));
      set_in(5'd0, 5'd2, 32'h5, 5'd3, 32'h6, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h100, 5'd9, 1'b1);
      issue();
      exm_rd = 5'd2; exm_we = 1'b1; exm_result = 32'hAAAA;
      wb_rd  = 5'd3; wb_we  = 1'b1; wb_result  = 32'hBBBB;
      step();
      exm_we = 1'b0; wb_we = 1'b0;

      // Reset mid-stall discards the held instruction
      out_ready = 1'b0;
      set_in(5'd5, 5'd1, 32'h77, 5'd2, 32'h88, 32'd0, 1'b0, 1'b0, 32'h200, 5'd4, 1'b1);
      issue();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_stall_a", alu_a, 32'd0);
      out_ready = 1'b1;
      repeat (3) step();

      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
